// File: rtl/int_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : int_ctrl                                                      |
// | Brief    : fixed-priority interrupt controller with req/ack/eoi CPU      |
// |            handshake and memory-mapped PEND/EN/MODE/STAT registers       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module int_ctrl #(
  parameter int              NIRQ   = 8,
  parameter int              DW     = 16,
  parameter logic [NIRQ-1:0] EN_RST = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            cs,
  input  logic            we,
  input  logic [1:0]      addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata,
  output logic            int_req,
  output logic [2:0]      int_id,
  input  logic            int_ack,
  input  logic            int_eoi
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  localparam logic [1:0] C_A_PEND = 2'd0;
  localparam logic [1:0] C_A_EN   = 2'd1;
  localparam logic [1:0] C_A_MODE = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [NIRQ-1:0] r_pend;
  logic [NIRQ-1:0] r_en;
  logic [NIRQ-1:0] r_mode;
  logic [NIRQ-1:0] r_irq_q;
  logic [2:0]      r_id;
  logic [2:0]      r_active;
  logic [DW-1:0]   r_rdata;

  logic            w_wr_pend;
  logic            w_wr_en;
  logic            w_wr_mode;
  logic            w_rd;
  logic [NIRQ-1:0] w_wdata;
  logic [NIRQ-1:0] w_set;
  logic [NIRQ-1:0] w_cand;
  logic [2:0]      w_winner;
  logic            w_ack_take;
  logic            w_withdraw;
  logic [NIRQ-1:0] w_ack_mask;
  logic [NIRQ-1:0] w_pend_nxt;
  logic [DW-1:0]   w_rd_val;
  logic            w_unused;

  assign w_wdata   = wdata[NIRQ-1:0];
  assign w_unused  = &{1'b0, wdata[DW-1:NIRQ]};
  assign w_rd      = cs & ~we;
  assign w_wr_pend = cs & we & (addr == C_A_PEND);
  assign w_wr_en   = cs & we & (addr == C_A_EN);
  assign w_wr_mode = cs & we & (addr == C_A_MODE);

  // Edge-mode bits set on a rising line, level-mode bits whenever the line is high
  assign w_set  = (r_mode & irq_in & ~r_irq_q) | (~r_mode & irq_in);
  assign w_cand = r_pend & r_en;

  always_comb begin
    w_winner = 3'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (w_cand[i]) w_winner = 3'(i);
    end
  end

  assign w_ack_take = (r_state == S_REQ) & int_ack;
  assign w_withdraw = (r_state == S_REQ) & w_wr_en & ~w_wdata[r_id];

  always_comb begin
    w_ack_mask = '0;
    if (w_ack_take && r_mode[r_id]) w_ack_mask[r_id] = 1'b1;
  end

  // Clears are applied first so a same-cycle set always survives
  always_comb begin
    w_pend_nxt = r_pend & ~w_ack_mask;
    if (w_wr_pend) w_pend_nxt = w_pend_nxt & ~w_wdata;
    w_pend_nxt = w_pend_nxt | w_set;
  end

  always_comb begin
    w_rd_val = '0;
    case (addr)
      2'd0:    w_rd_val[NIRQ-1:0] = r_pend;
      2'd1:    w_rd_val[NIRQ-1:0] = r_en;
      2'd2:    w_rd_val[NIRQ-1:0] = r_mode;
      default: w_rd_val[4:0]      = {r_state, r_active};
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_cand != '0) w_state_nxt = S_REQ;
      S_REQ: begin
        if (int_ack)         w_state_nxt = S_SVC;
        else if (w_withdraw) w_state_nxt = S_IDLE;
      end
      S_SVC:  if (int_eoi) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    int_req = (r_state == S_REQ);
    int_id  = r_id;
    rdata   = r_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend   <= '0;
      r_en     <= EN_RST;
      r_mode   <= '0;
      r_irq_q  <= '0;
      r_id     <= 3'd0;
      r_active <= 3'd0;
      r_rdata  <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_irq_q <= irq_in;
      if (w_wr_en)   r_en   <= w_wdata;
      if (w_wr_mode) r_mode <= w_wdata;
      if ((r_state == S_IDLE) && (w_cand != '0)) r_id <= w_winner;
      if (w_ack_take) r_active <= r_id;
      if (w_rd)       r_rdata  <= w_rd_val;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_int_ctrl                                                   |
// | Brief    : directed + randomized bench for int_ctrl against a behavioural |
// |            cycle model                                                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  irq_in = '0;
  logic        cs = 1'b0, we = 1'b0;
  logic [1:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        int_req;
  logic [2:0]  int_id;
  logic        int_ack = 1'b0, int_eoi = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: state 0=idle, 1=request outstanding, 2=in service
  logic [7:0]  m_pend, m_en, m_mode, m_irq_q;
  int          m_state, m_id, m_active;
  logic [15:0] m_rdata;

  int_ctrl #(.NIRQ(8), .DW(16), .EN_RST(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .cs(cs), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .int_req(int_req), .int_id(int_id),
    .int_ack(int_ack), .int_eoi(int_eoi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {8'h00, m_pend};
      2'd1:    return {8'h00, m_en};
      2'd2:    return {8'h00, m_mode};
      default: return 16'(m_state * 8 + m_active);
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] nxt_pend;
    if (!rst_n) begin
      m_pend = 0; m_en = 8'h00; m_mode = 0; m_irq_q = 0;
      m_state = 0; m_id = 0; m_active = 0; m_rdata = 0;
      return;
    end
    if (cs && !we) m_rdata = m_read(addr);
    nxt_pend = m_pend;
    if (cs && we && addr == 2'd0) nxt_pend = nxt_pend & ~wdata[7:0];
    case (m_state)
      0: begin
        for (int i = 7; i >= 0; i--)
          if (m_pend[i] && m_en[i]) begin m_id = i; m_state = 1; end
      end
      1: begin
        if (int_ack) begin
          m_active = m_id;
          if (m_mode[m_id]) nxt_pend[m_id] = 1'b0;
          m_state = 2;
        end else if (cs && we && addr == 2'd1 && !wdata[m_id]) begin
          m_state = 0;
        end
      end
      default: if (int_eoi) m_state = 0;
    endcase
    for (int i = 0; i < 8; i++)
      if (m_mode[i] ? (irq_in[i] && !m_irq_q[i]) : irq_in[i]) nxt_pend[i] = 1'b1;
    m_pend = nxt_pend;
    if (cs && we && addr == 2'd1) m_en = wdata[7:0];
    if (cs && we && addr == 2'd2) m_mode = wdata[7:0];
    m_irq_q = irq_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("int_req", int_req, (m_state == 1));
    if (m_state == 1) check("int_id", int_id, m_id);
    check("rdata", rdata, m_rdata);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cs = 1; we = 1; addr = a; wdata = d;
    tick();
    cs = 0; we = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    cs = 1; we = 0; addr = a;
    tick();
    cs = 0;
    d = rdata;
  endtask

  task automatic ack();
    int_ack = 1; tick(); int_ack = 0;
  endtask

  task automatic eoi();
    int_eoi = 1; tick(); int_eoi = 0;
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    irq_in = v; tick(); irq_in = 0;
  endtask

  task automatic wait_req(input int bound);
    int n = 0;
    while (!int_req && n < bound) begin tick(); n++; end
    check("wait_req_timeout", int_req, 1'b1);
  endtask

  logic [15:0] d;

  initial begin
    // 1: reset, edge-mode single source
    rst_n = 0; tick(); tick(); rst_n = 1;
    check("rst_req", int_req, 0);
    check("rst_id", int_id, 0);
    check("rst_rdata", rdata, 0);
    wr(1, 16'h0001); wr(2, 16'h0001);
    pulse_irq(8'h01);
    tick();
    check("t1_req", int_req, 1);
    check("t1_id", int_id, 0);
    ack();
    rd(0, d); check("t1_pend", d, 16'h0000);
    rd(3, d); check("t1_stat_svc", d, 16'h0010);
    eoi();
    rd(3, d); check("t1_stat_idle", d, 16'h0000);

    // 2: simultaneous sources resolve by priority
    wr(1, 16'h00FF); wr(2, 16'h00FF);
    pulse_irq(8'h24);
    tick();
    check("t2_id2", int_id, 2);
    ack(); eoi(); tick();
    check("t2_req5", int_req, 1);
    check("t2_id5", int_id, 5);
    ack(); eoi(); tick();
    check("t2_idle", int_req, 0);
    rd(0, d); check("t2_pend", d, 16'h0000);

    // 3: no preemption while a request is outstanding
    pulse_irq(8'h08);
    tick();
    check("t3_id3", int_id, 3);
    pulse_irq(8'h01); tick();
    check("t3_hold3", int_id, 3);
    ack(); eoi(); tick();
    check("t3_req0", int_req, 1);
    check("t3_id0", int_id, 0);
    ack(); eoi();

    // 4: withdraw by masking
    pulse_irq(8'h02);
    tick();
    check("t4_id1", int_id, 1);
    wr(1, 16'h0000);
    check("t4_withdrawn", int_req, 0);
    rd(3, d); check("t4_stat", d, 16'h0000);
    rd(0, d); check("t4_pend_kept", d, 16'h0002);
    wr(0, 16'h0002);
    rd(0, d); check("t4_pend_w1c", d, 16'h0000);

    // 5: level mode re-requests while the line stays high
    wr(2, 16'h0000); wr(1, 16'h0004);
    irq_in = 8'h04;
    wait_req(8);
    check("t5_id2", int_id, 2);
    ack(); eoi(); tick();
    check("t5_rereq", int_req, 1);
    check("t5_rereq_id", int_id, 2);
    irq_in = 0;
    wr(0, 16'h0004);
    ack(); eoi(); tick(); tick();
    check("t5_quiet", int_req, 0);

    // 6: reset from the service state
    wr(2, 16'h00FF); wr(1, 16'h00FF);
    pulse_irq(8'h08);
    wait_req(8);
    ack();
    pulse_irq(8'h40); tick();
    rst_n = 0; tick(); rst_n = 1;
    check("t6_req", int_req, 0);
    rd(3, d); check("t6_stat", d, 16'h0000);
    rd(0, d); check("t6_pend", d, 16'h0000);
    rd(1, d); check("t6_en", d, 16'h0000);
    eoi(); ack(); tick();
    check("t6_stray", int_req, 0);
    rd(3, d); check("t6_stat2", d, 16'h0000);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      irq_in  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      cs      = ($urandom_range(0, 3) == 0);
      we      = $urandom_range(0, 1) == 1;
      addr    = 2'($urandom_range(0, 3));
      wdata   = 16'($urandom);
      int_ack = ($urandom_range(0, 4) == 0);
      int_eoi = ($urandom_range(0, 4) == 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      tick();
    end
    cs = 0; we = 0; int_ack = 0; int_eoi = 0; irq_in = 0; rst_n = 1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
